// File: rtl/core_pkg.sv
// Shared trap definitions: CSR addresses, trap cause codes and mstatus/mip bit positions.
package core_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    typedef enum logic [3:0] {
        EXC_INSTR_MISALIGN = 4'd0,
        EXC_INSTR_FAULT    = 4'd1,
        EXC_ILLEGAL        = 4'd2,
        EXC_BREAKPOINT     = 4'd3,
        EXC_LOAD_MISALIGN  = 4'd4,
        EXC_LOAD_FAULT     = 4'd5,
        EXC_STORE_MISALIGN = 4'd6,
        EXC_STORE_FAULT    = 4'd7,
        EXC_ECALL_M        = 4'd11
    } exc_code_e;

    typedef enum logic [3:0] {
        IRQ_SW    = 4'd3,
        IRQ_TIMER = 4'd7,
        IRQ_EXT   = 4'd11
    } irq_code_e;

    // Bit positions shared by mie and mip
    localparam int IRQ_SW_BIT    = 3;
    localparam int IRQ_TIMER_BIT = 7;
    localparam int IRQ_EXT_BIT   = 11;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;
    localparam int MSTATUS_MPP_HI   = 12;

endpackage

// File: rtl/trap_csr_file.sv
// Trap CSR storage with read mux, WB write port and trap/mret update ports.
// mie/mip are live only when TRAP_CTRL_INTR_EN is defined; otherwise they read 0.
module trap_csr_file
    import core_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            csr_wr,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    input  logic            trap_set,
    input  logic [XLEN-1:0] trap_epc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_set,
    input  logic            ext_irq,
    input  logic            sw_irq,
    input  logic            timer_irq,
    output logic            mstatus_mie,
    output logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] mepc,
    output logic [2:0]      irq_pending
);

    logic            mie_bit_reg;
    logic            mpie_reg;
    logic [XLEN-1:0] mtvec_reg;
    logic [XLEN-1:0] mepc_reg;
    logic [XLEN-1:0] mcause_reg;
    logic [XLEN-1:0] mtval_reg;
    logic [XLEN-1:0] mie_rd;
    logic [XLEN-1:0] mip_rd;

    // WB write first; a same-cycle trap/mret then wins on the fields it owns
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mie_bit_reg <= 1'b0;
            mpie_reg    <= 1'b0;
            mtvec_reg   <= {MTVEC_RST[XLEN-1:2], 2'b00};
            mepc_reg    <= '0;
            mcause_reg  <= '0;
            mtval_reg   <= '0;
        end else begin
            if (csr_wr) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        mie_bit_reg <= csr_wdata[MSTATUS_MIE_BIT];
                        mpie_reg    <= csr_wdata[MSTATUS_MPIE_BIT];
                    end
                    CSR_MTVEC:  mtvec_reg  <= {csr_wdata[XLEN-1:2], 2'b00};
                    CSR_MEPC:   mepc_reg   <= {csr_wdata[XLEN-1:2], 2'b00};
                    CSR_MCAUSE: mcause_reg <= csr_wdata;
                    CSR_MTVAL:  mtval_reg  <= csr_wdata;
                    default: ;
                endcase
            end
            if (trap_set) begin
                mepc_reg    <= trap_epc;
                mcause_reg  <= trap_cause;
                mtval_reg   <= trap_tval;
                mpie_reg    <= mie_bit_reg;
                mie_bit_reg <= 1'b0;
            end else if (mret_set) begin
                mie_bit_reg <= mpie_reg;
                mpie_reg    <= 1'b1;
            end
        end
    end

`ifdef TRAP_CTRL_INTR_EN
    localparam logic [XLEN-1:0] IRQ_MASK =
        XLEN'((32'd1 << IRQ_EXT_BIT) | (32'd1 << IRQ_TIMER_BIT) | (32'd1 << IRQ_SW_BIT));

    logic [XLEN-1:0] mie_reg;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mie_reg <= '0;
        end else if (csr_wr && csr_addr == CSR_MIE) begin
            mie_reg <= csr_wdata & IRQ_MASK;
        end
    end

    always_comb begin
        mip_rd                = '0;
        mip_rd[IRQ_EXT_BIT]   = ext_irq;
        mip_rd[IRQ_TIMER_BIT] = timer_irq;
        mip_rd[IRQ_SW_BIT]    = sw_irq;
    end

    assign mie_rd      = mie_reg;
    assign irq_pending = {mie_reg[IRQ_EXT_BIT]   & mip_rd[IRQ_EXT_BIT],
                          mie_reg[IRQ_SW_BIT]    & mip_rd[IRQ_SW_BIT],
                          mie_reg[IRQ_TIMER_BIT] & mip_rd[IRQ_TIMER_BIT]};
`else
    logic unused_irq;
    assign unused_irq  = ^{ext_irq, sw_irq, timer_irq};
    assign mie_rd      = '0;
    assign mip_rd      = '0;
    assign irq_pending = '0;
`endif

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata[MSTATUS_MIE_BIT]                = mie_bit_reg;
                csr_rdata[MSTATUS_MPIE_BIT]               = mpie_reg;
                csr_rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
            end
            CSR_MIE:    csr_rdata = mie_rd;
            CSR_MTVEC:  csr_rdata = mtvec_reg;
            CSR_MEPC:   csr_rdata = mepc_reg;
            CSR_MCAUSE: csr_rdata = mcause_reg;
            CSR_MTVAL:  csr_rdata = mtval_reg;
            CSR_MIP:    csr_rdata = mip_rd;
            default:    csr_rdata = '0;
        endcase
    end

    assign mstatus_mie = mie_bit_reg;
    assign mtvec       = mtvec_reg;
    assign mepc        = mepc_reg;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: exception/mret/interrupt detection on the MEM instruction,
// one-cycle registered trap_take + trap_pc. Interrupts exist only with TRAP_CTRL_INTR_EN.
module trap_ctrl
    import core_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            mem_valid,
    input  logic [XLEN-1:0] mem_pc,
    input  logic            mem_exc_valid,
    input  logic [3:0]      mem_exc_code,
    input  logic [XLEN-1:0] mem_exc_tval,
    input  logic            mem_mret,
    input  logic            csr_wr,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    input  logic            ext_irq,
    input  logic            sw_irq,
    input  logic            timer_irq,
    output logic            trap_take,
    output logic [XLEN-1:0] trap_pc
);

    typedef enum logic {IDLE, TAKE} state_e;

    state_e          state_reg, state_next;
    logic            trap_take_reg, trap_take_next;
    logic [XLEN-1:0] trap_pc_reg, trap_pc_next;

    logic            trap_set, mret_set;
    logic [XLEN-1:0] trap_cause, trap_tval;
    logic            mstatus_mie;
    logic [XLEN-1:0] mtvec, mepc;
    logic [2:0]      irq_pending;
    irq_code_e       irq_code;

    trap_csr_file #(
        .XLEN      (XLEN),
        .MTVEC_RST (MTVEC_RST)
    ) u_csr (
        .clk         (clk),
        .rst_b       (rst_b),
        .csr_wr      (csr_wr),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .trap_set    (trap_set),
        .trap_epc    (mem_pc),
        .trap_cause  (trap_cause),
        .trap_tval   (trap_tval),
        .mret_set    (mret_set),
        .ext_irq     (ext_irq),
        .sw_irq      (sw_irq),
        .timer_irq   (timer_irq),
        .mstatus_mie (mstatus_mie),
        .mtvec       (mtvec),
        .mepc        (mepc),
        .irq_pending (irq_pending)
    );

    // irq_pending is {ext, sw, timer}; ext has top priority
    always_comb begin
        irq_code = IRQ_TIMER;
        if (irq_pending[2]) begin
            irq_code = IRQ_EXT;
        end else if (irq_pending[1]) begin
            irq_code = IRQ_SW;
        end
    end

    always_comb begin
        state_next     = state_reg;
        trap_take_next = 1'b0;
        trap_pc_next   = trap_pc_reg;
        trap_set       = 1'b0;
        mret_set       = 1'b0;
        trap_cause     = '0;
        trap_tval      = '0;
        case (state_reg)
            IDLE: begin
                if (mem_valid && mem_exc_valid) begin
                    trap_set       = 1'b1;
                    trap_cause     = {{(XLEN-4){1'b0}}, mem_exc_code};
                    trap_tval      = mem_exc_tval;
                    trap_pc_next   = mtvec;
                    trap_take_next = 1'b1;
                    state_next     = TAKE;
                end else if (mem_valid && mem_mret) begin
                    mret_set       = 1'b1;
                    trap_pc_next   = mepc;
                    trap_take_next = 1'b1;
                    state_next     = TAKE;
                end else if (mem_valid && mstatus_mie && (|irq_pending)) begin
                    trap_set       = 1'b1;
                    trap_cause     = {1'b1, {(XLEN-5){1'b0}}, irq_code};
                    trap_pc_next   = mtvec;
                    trap_take_next = 1'b1;
                    state_next     = TAKE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg     <= IDLE;
            trap_take_reg <= 1'b0;
            trap_pc_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            trap_take_reg <= trap_take_next;
            trap_pc_reg   <= trap_pc_next;
        end
    end

    assign trap_take = trap_take_reg;
    assign trap_pc   = trap_pc_reg;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: architectural model checked every cycle plus directed literal checks.
// Interrupt expectations follow TRAP_CTRL_INTR_EN.
module tb_trap_ctrl;
    import core_pkg::*;

    localparam logic [31:0] MTVEC_RST = 32'h0000_1003;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_pc = '0;
    logic        mem_exc_valid = 1'b0;
    logic [3:0]  mem_exc_code = '0;
    logic [31:0] mem_exc_tval = '0;
    logic        mem_mret = 1'b0;
    logic        csr_wr = 1'b0;
    logic [11:0] csr_addr = CSR_MSTATUS;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        ext_irq = 1'b0;
    logic        sw_irq = 1'b0;
    logic        timer_irq = 1'b0;
    logic        trap_take;
    logic [31:0] trap_pc;

    trap_ctrl #(.XLEN(32), .MTVEC_RST(MTVEC_RST)) dut (
        .clk(clk), .rst_b(rst_b),
        .mem_valid(mem_valid), .mem_pc(mem_pc),
        .mem_exc_valid(mem_exc_valid), .mem_exc_code(mem_exc_code), .mem_exc_tval(mem_exc_tval),
        .mem_mret(mem_mret),
        .csr_wr(csr_wr), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .ext_irq(ext_irq), .sw_irq(sw_irq), .timer_irq(timer_irq),
        .trap_take(trap_take), .trap_pc(trap_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Architectural model of the CSRs and the redirect output
    typedef struct packed {
        logic        mie;
        logic        mpie;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mtval;
        logic [31:0] mien;
        logic [31:0] pc;
        logic        take;
    } model_t;

    model_t m;

    function automatic logic [31:0] model_mip();
`ifdef TRAP_CTRL_INTR_EN
        return ({31'b0, ext_irq} << 11) | ({31'b0, timer_irq} << 7) | ({31'b0, sw_irq} << 3);
`else
        return 32'h0;
`endif
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r = '0;
        r.mtvec = MTVEC_RST & ~32'h3;
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            CSR_MSTATUS: return 32'h1800 | ({31'b0, m.mie} << 3) | ({31'b0, m.mpie} << 7);
            CSR_MIE:     return m.mien;
            CSR_MTVEC:   return m.mtvec;
            CSR_MEPC:    return m.mepc;
            CSR_MCAUSE:  return m.mcause;
            CSR_MTVAL:   return m.mtval;
            CSR_MIP:     return model_mip();
            default:     return 32'h0;
        endcase
    endfunction

    function automatic model_t model_step(input model_t s);
        model_t n;
        logic [31:0] pend;
        n = s;
        n.take = 1'b0;
        if (csr_wr) begin
            case (csr_addr)
                CSR_MSTATUS: begin n.mie = csr_wdata[3]; n.mpie = csr_wdata[7]; end
                CSR_MTVEC:   n.mtvec = csr_wdata & ~32'h3;
                CSR_MEPC:    n.mepc = csr_wdata & ~32'h3;
                CSR_MCAUSE:  n.mcause = csr_wdata;
                CSR_MTVAL:   n.mtval = csr_wdata;
`ifdef TRAP_CTRL_INTR_EN
                CSR_MIE:     n.mien = csr_wdata & 32'h888;
`endif
                default: ;
            endcase
        end
        if (!s.take && mem_valid) begin
            pend = s.mien & model_mip();
            if (mem_exc_valid) begin
                n.take = 1'b1; n.pc = s.mtvec;
                n.mepc = mem_pc; n.mcause = {28'b0, mem_exc_code}; n.mtval = mem_exc_tval;
                n.mpie = s.mie; n.mie = 1'b0;
            end else if (mem_mret) begin
                n.take = 1'b1; n.pc = s.mepc;
                n.mie = s.mpie; n.mpie = 1'b1;
            end else if (s.mie && pend != 0) begin
                n.take = 1'b1; n.pc = s.mtvec;
                n.mepc = mem_pc; n.mtval = 32'h0;
                n.mcause = pend[11] ? 32'h8000_000B : (pend[3] ? 32'h8000_0003 : 32'h8000_0007);
                n.mpie = s.mie; n.mie = 1'b0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) m <= model_reset();
        else        m <= model_step(m);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_trap_take", {31'b0, trap_take}, {31'b0, m.take});
            if (m.take) check("cyc_trap_pc", trap_pc, m.pc);
            check("cyc_csr_rdata", csr_rdata, model_read(csr_addr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_wr = 1'b1; csr_addr = a; csr_wdata = d;
        tick();
        csr_wr = 1'b0;
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        check(name, csr_rdata, exp);
    endtask

    task automatic drive_exc(input logic [31:0] pc, input logic [3:0] code, input logic [31:0] tval);
        mem_valid = 1'b1; mem_pc = pc; mem_exc_valid = 1'b1; mem_exc_code = code; mem_exc_tval = tval;
    endtask

    task automatic clear_mem();
        mem_valid = 1'b0; mem_exc_valid = 1'b0; mem_mret = 1'b0;
        mem_exc_code = '0; mem_exc_tval = '0;
    endtask

    initial begin
        repeat (2) tick();
        $display("tb: reset state");
        check("rst_trap_take", {31'b0, trap_take}, 32'h0);
        check("rst_trap_pc", trap_pc, 32'h0);
        rd("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
        rd("rst_mtvec", CSR_MTVEC, 32'h0000_1000);
        cmp_en = 1'b1;
        rst_b = 1'b1;
        tick();

        $display("tb: exception pc=00000100 code=2");
        csr_write(CSR_MTVEC, 32'h8000_0000);
        csr_write(CSR_MSTATUS, 32'h0000_0008);
        drive_exc(32'h100, 4'd2, 32'h1234);
        tick();
        clear_mem();
        check("exc_take", {31'b0, trap_take}, 32'h1);
        check("exc_pc", trap_pc, 32'h8000_0000);
        rd("exc_mepc", CSR_MEPC, 32'h100);
        rd("exc_mcause", CSR_MCAUSE, 32'h2);
        rd("exc_mtval", CSR_MTVAL, 32'h1234);
        rd("exc_mstatus", CSR_MSTATUS, 32'h0000_1880);
        tick();
        check("exc_pulse_end", {31'b0, trap_take}, 32'h0);

        $display("tb: mret mepc=00000104");
        csr_write(CSR_MEPC, 32'h107);
        rd("mepc_align", CSR_MEPC, 32'h104);
        mem_valid = 1'b1; mem_mret = 1'b1;
        tick();
        clear_mem();
        check("mret_take", {31'b0, trap_take}, 32'h1);
        check("mret_pc", trap_pc, 32'h104);
        rd("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);
        rd("mret_mepc", CSR_MEPC, 32'h104);
        tick();
        check("mret_pulse_end", {31'b0, trap_take}, 32'h0);

        $display("tb: exception + mret + irq same cycle");
        csr_write(CSR_MIE, 32'h80);
        timer_irq = 1'b1;
        drive_exc(32'h300, 4'd5, 32'hABC);
        mem_mret = 1'b1;
        tick();
        clear_mem();
        check("prio_take", {31'b0, trap_take}, 32'h1);
        check("prio_pc", trap_pc, 32'h8000_0000);
        rd("prio_mcause", CSR_MCAUSE, 32'h5);
        rd("prio_mepc", CSR_MEPC, 32'h300);
        rd("prio_mstatus", CSR_MSTATUS, 32'h0000_1880);
        tick();
        check("prio_single1", {31'b0, trap_take}, 32'h0);
        tick();
        check("prio_single2", {31'b0, trap_take}, 32'h0);
        timer_irq = 1'b0;

        $display("tb: back-to-back exceptions with same-cycle mtvec write");
        drive_exc(32'h400, 4'd4, 32'h44);
        csr_wr = 1'b1; csr_addr = CSR_MTVEC; csr_wdata = 32'h9000_0001;
        tick();
        csr_wr = 1'b0;
        drive_exc(32'h404, 4'd6, 32'h66);
        check("b2b_take", {31'b0, trap_take}, 32'h1);
        check("b2b_pc_old_mtvec", trap_pc, 32'h8000_0000);
        tick();
        clear_mem();
        check("b2b_no_second", {31'b0, trap_take}, 32'h0);
        rd("b2b_mepc", CSR_MEPC, 32'h400);
        rd("b2b_mcause", CSR_MCAUSE, 32'h4);
        rd("b2b_mtval", CSR_MTVAL, 32'h44);
        rd("b2b_mtvec", CSR_MTVEC, 32'h9000_0000);
        tick();

        $display("tb: timer interrupt pc=00000200");
        csr_write(CSR_MSTATUS, 32'h0000_0008);
        csr_write(CSR_MIE, 32'h80);
        timer_irq = 1'b1;
        mem_valid = 1'b1; mem_pc = 32'h200;
        tick();
        clear_mem();
`ifdef TRAP_CTRL_INTR_EN
        check("irq_take", {31'b0, trap_take}, 32'h1);
        check("irq_pc", trap_pc, 32'h9000_0000);
        rd("irq_mcause", CSR_MCAUSE, 32'h8000_0007);
        rd("irq_mepc", CSR_MEPC, 32'h200);
        rd("irq_mtval", CSR_MTVAL, 32'h0);
        rd("irq_mip", CSR_MIP, 32'h80);
        rd("irq_mie", CSR_MIE, 32'h80);
        tick();
        timer_irq = 1'b0;
        $display("tb: ext > sw > timer priority");
        csr_write(CSR_MSTATUS, 32'h0000_0008);
        csr_write(CSR_MIE, 32'hFFFF_FFFF);
        ext_irq = 1'b1; sw_irq = 1'b1; timer_irq = 1'b1;
        mem_valid = 1'b1; mem_pc = 32'h210;
        tick();
        clear_mem();
        check("irq_ext_take", {31'b0, trap_take}, 32'h1);
        rd("irq_ext_mcause", CSR_MCAUSE, 32'h8000_000B);
        rd("irq_mie_mask", CSR_MIE, 32'h888);
        tick();
        ext_irq = 1'b0;
        csr_write(CSR_MSTATUS, 32'h0000_0008);
        mem_valid = 1'b1; mem_pc = 32'h220;
        tick();
        clear_mem();
        check("irq_sw_take", {31'b0, trap_take}, 32'h1);
        rd("irq_sw_mcause", CSR_MCAUSE, 32'h8000_0003);
        rd("irq_sw_mepc", CSR_MEPC, 32'h220);
        tick();
`else
        check("noirq_take", {31'b0, trap_take}, 32'h0);
        rd("noirq_mip", CSR_MIP, 32'h0);
        rd("noirq_mie", CSR_MIE, 32'h0);
        rd("noirq_mstatus", CSR_MSTATUS, 32'h0000_1808);
        rd("noirq_mepc", CSR_MEPC, 32'h400);
        tick();
`endif
        ext_irq = 1'b0; sw_irq = 1'b0; timer_irq = 1'b0;

        $display("tb: reset asserted during TAKE");
        drive_exc(32'h500, 4'd1, 32'h0);
        tick();
        clear_mem();
        check("rtake_take", {31'b0, trap_take}, 32'h1);
        #2;
        rst_b = 1'b0;
        #1;
        check("rtake_async_drop", {31'b0, trap_take}, 32'h0);
        rd("rtake_mstatus", CSR_MSTATUS, 32'h0000_1800);
        rd("rtake_mtvec", CSR_MTVEC, 32'h0000_1000);
        rd("rtake_mepc", CSR_MEPC, 32'h0);
        rd("rtake_mcause", CSR_MCAUSE, 32'h0);
        tick();
        rd("rtake_mtval", CSR_MTVAL, 32'h0);
        rd("rtake_mie", CSR_MIE, 32'h0);
        check("rtake_trap_pc", trap_pc, 32'h0);
        rst_b = 1'b1;
        tick();

        $display("tb: exception after reset release");
        drive_exc(32'h600, 4'd3, 32'h0);
        tick();
        clear_mem();
        check("post_rst_take", {31'b0, trap_take}, 32'h1);
        check("post_rst_pc", trap_pc, 32'h0000_1000);
        rd("post_rst_mcause", CSR_MCAUSE, 32'h3);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
